// File: rtl/i281_seq_shift_unit_if.sv
// i281_seq_shift_unit_if
//   Handshake and data bundle for the sequential shift unit.
//   master: requester (drives Start and the operand fields, receives status/result)
//   slave : the shift unit itself
//   Signals:
//     Start     request, sampled by the unit only while idle
//     LRSelect  0 = shift toward MSB, 1 = shift toward LSB
//     Amount    number of single-bit shifts (0 .. 2^CNT_W-1)
//     FillBit   value shifted into the vacated end
//     DataIn    operand
//     Busy      operation in progress (SHIFT or DONE)
//     Done      one-cycle result-valid pulse
//     DataOut   working/result register
//     CarryOut  last bit shifted out
//     ZeroFlag  DataOut == 0
interface i281_seq_shift_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             Start;
   logic             LRSelect;
   logic [CNT_W-1:0] Amount;
   logic             FillBit;
   logic [WIDTH-1:0] DataIn;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] DataOut;
   logic             CarryOut;
   logic             ZeroFlag;

   modport master (
      output Start, LRSelect, Amount, FillBit, DataIn,
      input  Busy, Done, DataOut, CarryOut, ZeroFlag
   );

   modport slave (
      input  Start, LRSelect, Amount, FillBit, DataIn,
      output Busy, Done, DataOut, CarryOut, ZeroFlag
   );
endinterface

// File: rtl/i281_seq_shift_unit.sv
// i281_seq_shift_unit
//   Multi-cycle shift unit: loads an operand on Start and shifts it one bit
//   per clock, left or right, for Amount positions, filling from a latched
//   fill bit. The last bit shifted out is kept as CarryOut; Done pulses for
//   one cycle when the result in DataOut is final.
//   Ports:
//     Clock    system clock, rising edge
//     Reset_n  synchronous active-low reset (abandons any operation)
//     bus      slave side of i281_seq_shift_unit_if (Start/operands in,
//              Busy/Done/DataOut/CarryOut/ZeroFlag out)
module i281_seq_shift_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   i281_seq_shift_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic             dir_q;
   logic             fill_q;
   logic [WIDTH-1:0] data_q;
   logic             carry_q;

   // Next-state logic; the counter is checked before its decrement so SHIFT
   // is left on the last shift and the counter never wraps.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d = (bus.Amount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (count_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.Start) begin
                  data_q  <= bus.DataIn;
                  carry_q <= 1'b0;
                  count_q <= bus.Amount;
                  dir_q   <= bus.LRSelect;
                  fill_q  <= bus.FillBit;
               end
            end
            SHIFT: begin
               if (!dir_q) begin
                  carry_q <= data_q[WIDTH-1];
                  data_q  <= {data_q[WIDTH-2:0], fill_q};
               end else begin
                  carry_q <= data_q[0];
                  data_q  <= {fill_q, data_q[WIDTH-1:1]};
               end
               count_q <= count_q - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.Busy     = (state_q != IDLE);
   assign bus.Done     = (state_q == DONE);
   assign bus.DataOut  = data_q;
   assign bus.CarryOut = carry_q;
   assign bus.ZeroFlag = (data_q == '0);

endmodule
